mem_req_scheduler: RTL and testbench
====================================

# mem_req_scheduler

Sequences the shared TileLink-UL A/D port between the data-cache writeback path (requester 0, PutFullData) and the refill path (requester 1, Get). It grants one requester, registers its request, drives it onto channel A, and holds exactly one transaction outstanding until the matching D response returns. Each response is steered back to its owner. Writes have fixed priority over reads; a starvation counter forces a read grant after a bounded run of write grants.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive write grants while a read is pending before a read grant is forced; range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in_0_valid / io_in_0_ready  in/out  1  write request handshake.
- io_in_0_bits_address  input  ADDR_W  write address.
- io_in_0_bits_data  input  DATA_W  write data.
- io_in_1_valid / io_in_1_ready  in/out  1  read request handshake.
- io_in_1_bits_address  input  ADDR_W  read address.
- io_a_valid / io_a_ready  out/in  1  channel A handshake.
- io_a_bits_opcode  output  3  3'h0 PutFullData, 3'h4 Get.
- io_a_bits_address  output  ADDR_W  registered request address.
- io_a_bits_data  output  DATA_W  registered write data; 0 for Get.
- io_a_bits_source  output  1  requester id: 0 write, 1 read.
- io_d_valid / io_d_ready  in/out  1  channel D handshake.
- io_d_bits_opcode  input  3  3'h0 AccessAck, 3'h1 AccessAckData.
- io_d_bits_source  input  1  response id.
- io_d_bits_data  input  DATA_W  read data.
- io_resp_0_valid  output  1  one-cycle write-complete pulse.
- io_resp_1_valid  output  1  one-cycle read-complete pulse.
- io_resp_1_bits_data  output  DATA_W  read data; valid with io_resp_1_valid.
- io_busy  output  1  high whenever state is not IDLE.
- io_err  output  1  sticky; set on a mismatched D response; cleared only by reset.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: io_in_0_ready = ~starve_force. io_in_1_ready = starve_force | ~io_in_0_valid. starve_force = (starve_cnt == STARVE_LIMIT) & io_in_1_valid.
- A grant is an input fire in IDLE. On a grant, the block registers address, data (0 for reads), opcode and source, then moves to REQ.
- REQ: io_a_valid = 1 and the registered fields drive A. Fields are stable until io_a_ready. On A fire, the block moves to WAIT.
- WAIT: io_d_ready = 1. On D fire:
  - Matching response: source equals the stored source, and opcode is AccessAck for a write or AccessAckData for a read. The block pulses io_resp_<source>_valid in the same cycle (combinational from D fire), passes io_d_bits_data on io_resp_1_bits_data, and moves to IDLE.
  - Mismatched response: the block consumes it, sets io_err, emits no resp pulse, and stays in WAIT.
- io_in_*_ready is 0 outside IDLE. io_a_valid is 0 outside REQ. io_d_ready is 0 outside WAIT.
- Starvation counter, width 4, saturates at STARVE_LIMIT:
  - A write grant while io_in_1_valid = 1 increments it.
  - A read grant clears it to 0.
  - A write grant with no read pending leaves it unchanged.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, starve_cnt = 0, io_err = 0, registered fields = 0.
- Reset values of outputs: io_a_valid = 0, io_d_ready = 0, io_resp_*_valid = 0, io_busy = 0, io_a_bits_* = 0. io_in_*_ready follows the IDLE equations.
- Asserting reset mid-transaction discards the in-flight request with no resp pulse.
- Latency: grant at cycle N gives io_a_valid at N+1 (minimum). With io_a_ready = 1 and the D response one cycle after A fire, the resp pulse is at N+2 and the next grant is possible at N+3.
- The block allows only one outstanding transaction. A new grant can occur only in the cycle after the resp pulse, never in the same cycle.
- Simultaneous valid on both inputs in IDLE: the write wins unless starve_force is true.
- A D response that arrives while not in WAIT is ignored, because io_d_ready = 0.

## Test plan
- Single write: in0 valid, address 0x1000, data 0xDEADBEEF → A carries opcode 0, source 0, the same address and data one cycle after the grant. D AccessAck with source 0 → io_resp_0_valid pulses for 1 cycle; io_busy falls the next cycle.
- Single read: in1, address 0x2000 → A opcode 4, data 0. D AccessAckData with source 1 and data 0x12345678 → io_resp_1_valid = 1 with data 0x12345678.
- Starvation: in0 and in1 both held valid, STARVE_LIMIT = 4 → grants run W, W, W, W, R, then W resumes and starve_cnt = 0 after the read.
- Backpressure: io_a_ready held 0 for 5 cycles in REQ → A fields stay constant, io_in_*_ready = 0, and the transaction completes normally once ready is released.
- Mismatch: in WAIT for a read, D arrives with source 0 → io_err = 1 (sticky), no resp pulse, still WAIT. A following correct D completes the transaction.
- Reset while in WAIT → all outputs reach their reset values immediately, io_err = 0, and the next request is granted normally after release.

Source files
------------

// File: rtl/mem_req_scheduler_if.sv
// Request/response bundle for mem_req_scheduler: two requester ports, TileLink-UL A/D
// channels and the per-requester completion signals.
interface mem_req_scheduler_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              io_in_0_valid;
    logic              io_in_0_ready;
    logic [ADDR_W-1:0] io_in_0_bits_address;
    logic [DATA_W-1:0] io_in_0_bits_data;

    logic              io_in_1_valid;
    logic              io_in_1_ready;
    logic [ADDR_W-1:0] io_in_1_bits_address;

    logic              io_a_valid;
    logic              io_a_ready;
    logic [2:0]        io_a_bits_opcode;
    logic [ADDR_W-1:0] io_a_bits_address;
    logic [DATA_W-1:0] io_a_bits_data;
    logic              io_a_bits_source;

    logic              io_d_valid;
    logic              io_d_ready;
    logic [2:0]        io_d_bits_opcode;
    logic              io_d_bits_source;
    logic [DATA_W-1:0] io_d_bits_data;

    logic              io_resp_0_valid;
    logic              io_resp_1_valid;
    logic [DATA_W-1:0] io_resp_1_bits_data;

    logic              io_busy;
    logic              io_err;

    // Scheduler side
    modport slave (
        input  io_in_0_valid, io_in_0_bits_address, io_in_0_bits_data,
        output io_in_0_ready,
        input  io_in_1_valid, io_in_1_bits_address,
        output io_in_1_ready,
        output io_a_valid, io_a_bits_opcode, io_a_bits_address, io_a_bits_data, io_a_bits_source,
        input  io_a_ready,
        input  io_d_valid, io_d_bits_opcode, io_d_bits_source, io_d_bits_data,
        output io_d_ready,
        output io_resp_0_valid, io_resp_1_valid, io_resp_1_bits_data,
        output io_busy, io_err
    );

    // Requesters and memory side
    modport master (
        output io_in_0_valid, io_in_0_bits_address, io_in_0_bits_data,
        input  io_in_0_ready,
        output io_in_1_valid, io_in_1_bits_address,
        input  io_in_1_ready,
        input  io_a_valid, io_a_bits_opcode, io_a_bits_address, io_a_bits_data, io_a_bits_source,
        output io_a_ready,
        output io_d_valid, io_d_bits_opcode, io_d_bits_source, io_d_bits_data,
        input  io_d_ready,
        input  io_resp_0_valid, io_resp_1_valid, io_resp_1_bits_data,
        input  io_busy, io_err
    );
endinterface

// File: rtl/mem_req_scheduler.sv
// Arbitrates writeback (PutFullData) and refill (Get) onto one TileLink-UL A/D port,
// one transaction in flight, writes first with a starvation escape for reads.
module mem_req_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                clock,
    input  logic                reset,
    mem_req_scheduler_if.slave  io
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [2:0] OP_PUT_FULL  = 3'h0;
    localparam logic [2:0] OP_GET       = 3'h4;
    localparam logic [2:0] OP_ACK       = 3'h0;
    localparam logic [2:0] OP_ACK_DATA  = 3'h1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic              source;
    } a_req_t;

    state_e           state_q, state_d;
    a_req_t           req_q, req_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;

    logic             starve_force;
    logic             in0_ready, in1_ready;
    logic             a_valid, d_ready;
    logic             resp0_valid, resp1_valid;
    logic             d_match;

    // State and request registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

    // Next-state, grant and response steering
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        starve_cnt_d = starve_cnt_q;
        err_d        = err_q;
        starve_force = 1'b0;
        in0_ready    = 1'b0;
        in1_ready    = 1'b0;
        a_valid      = 1'b0;
        d_ready      = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        d_match      = 1'b0;

        case (state_q)
            IDLE: begin
                starve_force = (starve_cnt_q == STARVE_MAX) && io.io_in_1_valid;
                in0_ready    = ~starve_force;
                in1_ready    = starve_force | ~io.io_in_0_valid;
                if (io.io_in_0_valid && in0_ready) begin
                    req_d.opcode  = OP_PUT_FULL;
                    req_d.address = io.io_in_0_bits_address;
                    req_d.data    = io.io_in_0_bits_data;
                    req_d.source  = 1'b0;
                    // Only writes that bypass a waiting read count toward starvation
                    if (io.io_in_1_valid && (starve_cnt_q != STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                    state_d = REQ;
                end else if (io.io_in_1_valid && in1_ready) begin
                    req_d.opcode  = OP_GET;
                    req_d.address = io.io_in_1_bits_address;
                    req_d.data    = '0;
                    req_d.source  = 1'b1;
                    starve_cnt_d  = '0;
                    state_d       = REQ;
                end
            end
            REQ: begin
                a_valid = 1'b1;
                if (io.io_a_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                d_ready = 1'b1;
                if (io.io_d_valid) begin
                    d_match = (io.io_d_bits_source == req_q.source) &&
                              (io.io_d_bits_opcode == (req_q.source ? OP_ACK_DATA : OP_ACK));
                    if (d_match) begin
                        resp0_valid = ~req_q.source;
                        resp1_valid = req_q.source;
                        state_d     = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign io.io_in_0_ready       = in0_ready;
    assign io.io_in_1_ready       = in1_ready;
    assign io.io_a_valid          = a_valid;
    assign io.io_a_bits_opcode    = req_q.opcode;
    assign io.io_a_bits_address   = req_q.address;
    assign io.io_a_bits_data      = req_q.data;
    assign io.io_a_bits_source    = req_q.source;
    assign io.io_d_ready          = d_ready;
    assign io.io_resp_0_valid     = resp0_valid;
    assign io.io_resp_1_valid     = resp1_valid;
    assign io.io_resp_1_bits_data = io.io_d_bits_data;
    assign io.io_busy             = (state_q != IDLE);
    assign io.io_err              = err_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: stimulus pushes expected A beats and responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_req_scheduler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_req_scheduler_if #(.ADDR_W(32), .DATA_W(32)) sif ();

    mem_req_scheduler #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock (clk),
        .reset (rst_n),
        .io    (sif)
    );

    typedef struct {
        logic [2:0]  opcode;
        logic [31:0] address;
        logic [31:0] data;
        logic        source;
    } exp_a_t;

    typedef struct {
        logic        which;
        logic [31:0] data;
    } exp_resp_t;

    exp_a_t    exp_a_q[$];
    exp_resp_t exp_resp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard monitor: compares every A fire and every response pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.io_a_valid && sif.io_a_ready) begin
                if (exp_a_q.size() == 0) begin
                    fail_now("unexpected_a_fire");
                end else begin
                    exp_a_t e;
                    e = exp_a_q.pop_front();
                    chk("a_opcode",  64'(sif.io_a_bits_opcode),  64'(e.opcode));
                    chk("a_address", 64'(sif.io_a_bits_address), 64'(e.address));
                    chk("a_data",    64'(sif.io_a_bits_data),    64'(e.data));
                    chk("a_source",  64'(sif.io_a_bits_source),  64'(e.source));
                end
            end
            if (sif.io_resp_0_valid && sif.io_resp_1_valid) begin
                fail_now("both_resp_pulses");
            end else if (sif.io_resp_0_valid || sif.io_resp_1_valid) begin
                if (exp_resp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    exp_resp_t r;
                    r = exp_resp_q.pop_front();
                    chk("resp_which", 64'(sif.io_resp_1_valid), 64'(r.which));
                    if (r.which) chk("resp_1_data", 64'(sif.io_resp_1_bits_data), 64'(r.data));
                end
            end
        end
    end

    // Caller sits just after a rising edge; returns just after the edge following the grant
    task automatic grant(input bit rd, input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        if (rd) begin
            sif.io_in_1_valid        = 1'b1;
            sif.io_in_1_bits_address = addr;
            exp_a_q.push_back('{3'h4, addr, 32'h0, 1'b1});
        end else begin
            sif.io_in_0_valid        = 1'b1;
            sif.io_in_0_bits_address = addr;
            sif.io_in_0_bits_data    = data;
            exp_a_q.push_back('{3'h0, addr, data, 1'b0});
        end
        #1;
        while (!(rd ? sif.io_in_1_ready : sif.io_in_0_ready)) begin
            @(posedge clk); #2;
            n++;
            if (n > 50) begin
                fail_now("grant_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        if (rd) sif.io_in_1_valid = 1'b0;
        else    sif.io_in_0_valid = 1'b0;
        chk("a_valid_after_grant", 64'(sif.io_a_valid), 64'd1);
        chk("busy_after_grant",    64'(sif.io_busy),    64'd1);
    endtask

    task automatic wait_d();
        int n;
        n = 0;
        while (!sif.io_d_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                fail_now("wait_d_timeout");
                break;
            end
        end
    endtask

    // Drive one D beat for a cycle; expected resp pushed only for a matching beat
    task automatic d_beat(input bit src, input logic [2:0] op, input logic [31:0] data,
                          input bit expect_resp);
        if (expect_resp) exp_resp_q.push_back('{src, data});
        sif.io_d_valid       = 1'b1;
        sif.io_d_bits_source = src;
        sif.io_d_bits_opcode = op;
        sif.io_d_bits_data   = data;
        @(posedge clk); #1;
        sif.io_d_valid       = 1'b0;
        sif.io_d_bits_data   = '0;
    endtask

    initial begin
        sif.io_in_0_valid        = 1'b0;
        sif.io_in_0_bits_address = '0;
        sif.io_in_0_bits_data    = '0;
        sif.io_in_1_valid        = 1'b0;
        sif.io_in_1_bits_address = '0;
        sif.io_a_ready           = 1'b1;
        sif.io_d_valid           = 1'b0;
        sif.io_d_bits_opcode     = '0;
        sif.io_d_bits_source     = 1'b0;
        sif.io_d_bits_data       = '0;

        // Reset values
        #12;
        chk("rst_a_valid",   64'(sif.io_a_valid),        64'd0);
        chk("rst_d_ready",   64'(sif.io_d_ready),        64'd0);
        chk("rst_busy",      64'(sif.io_busy),           64'd0);
        chk("rst_err",       64'(sif.io_err),            64'd0);
        chk("rst_resp0",     64'(sif.io_resp_0_valid),   64'd0);
        chk("rst_a_addr",    64'(sif.io_a_bits_address), 64'd0);
        chk("rst_in0_ready", 64'(sif.io_in_0_ready),     64'd1);
        chk("rst_in1_ready", 64'(sif.io_in_1_ready),     64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write
        grant(1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_d();
        d_beat(1'b0, 3'h0, 32'h0, 1'b1);
        chk("write_busy_falls", 64'(sif.io_busy), 64'd0);

        // Single read
        grant(1'b1, 32'h0000_2000, 32'h0);
        wait_d();
        d_beat(1'b1, 3'h1, 32'h1234_5678, 1'b1);
        chk("read_busy_falls", 64'(sif.io_busy), 64'd0);

        // Starvation: both held valid, expect W W W W R W
        for (int k = 0; k < 6; k++) begin
            if (k == 4) exp_a_q.push_back('{3'h4, 32'h0000_4000, 32'h0, 1'b1});
            else        exp_a_q.push_back('{3'h0, 32'h0000_3000, 32'hA5A5_A5A5, 1'b0});
        end
        sif.io_in_0_valid        = 1'b1;
        sif.io_in_0_bits_address = 32'h0000_3000;
        sif.io_in_0_bits_data    = 32'hA5A5_A5A5;
        sif.io_in_1_valid        = 1'b1;
        sif.io_in_1_bits_address = 32'h0000_4000;
        for (int k = 0; k < 6; k++) begin
            wait_d();
            if (k == 5) begin
                sif.io_in_0_valid = 1'b0;
                sif.io_in_1_valid = 1'b0;
            end
            if (k == 4) d_beat(1'b1, 3'h1, 32'h0000_0044, 1'b1);
            else        d_beat(1'b0, 3'h0, 32'h0, 1'b1);
        end

        // Backpressure on channel A
        sif.io_a_ready = 1'b0;
        grant(1'b0, 32'h0000_5000, 32'h1111_2222);
        sif.io_in_1_valid        = 1'b1;
        sif.io_in_1_bits_address = 32'h0000_9000;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_a_valid", 64'(sif.io_a_valid),        64'd1);
            chk("bp_a_addr",  64'(sif.io_a_bits_address), 64'h5000);
            chk("bp_a_data",  64'(sif.io_a_bits_data),    64'h1111_2222);
            chk("bp_a_op",    64'(sif.io_a_bits_opcode),  64'd0);
            chk("bp_in0_rdy", 64'(sif.io_in_0_ready),     64'd0);
            chk("bp_in1_rdy", 64'(sif.io_in_1_ready),     64'd0);
            @(posedge clk); #2;
        end
        sif.io_in_1_valid = 1'b0;
        sif.io_a_ready    = 1'b1;
        @(posedge clk); #1;
        wait_d();
        d_beat(1'b0, 3'h0, 32'h0, 1'b1);
        chk("bp_busy_falls", 64'(sif.io_busy), 64'd0);

        // Mismatched D for a read, then the correct one
        grant(1'b1, 32'h0000_6000, 32'h0);
        wait_d();
        d_beat(1'b0, 3'h0, 32'h0, 1'b0);
        chk("mm_err",     64'(sif.io_err),     64'd1);
        chk("mm_d_ready", 64'(sif.io_d_ready), 64'd1);
        chk("mm_busy",    64'(sif.io_busy),    64'd1);
        d_beat(1'b1, 3'h1, 32'hCAFE_F00D, 1'b1);
        chk("mm_err_sticky", 64'(sif.io_err),  64'd1);
        chk("mm_busy_falls", 64'(sif.io_busy), 64'd0);

        // Reset while waiting for D
        grant(1'b0, 32'h0000_7000, 32'h0000_0077);
        wait_d();
        rst_n = 1'b0;
        #1;
        chk("wrst_busy",    64'(sif.io_busy),           64'd0);
        chk("wrst_d_ready", 64'(sif.io_d_ready),        64'd0);
        chk("wrst_err",     64'(sif.io_err),            64'd0);
        chk("wrst_a_valid", 64'(sif.io_a_valid),        64'd0);
        chk("wrst_a_addr",  64'(sif.io_a_bits_address), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        grant(1'b1, 32'h0000_8000, 32'h0);
        wait_d();
        d_beat(1'b1, 3'h1, 32'h0BAD_F00D, 1'b1);
        chk("post_rst_busy", 64'(sif.io_busy), 64'd0);
        chk("post_rst_err",  64'(sif.io_err),  64'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("exp_a_drained",    64'(exp_a_q.size()),    64'd0);
        chk("exp_resp_drained", 64'(exp_resp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
